// File: rtl/count_sequencer_pkg.sv
// Shared types for the count sequencer: controller states and mode bit positions.
package count_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MODE_RELOAD = 0;
    localparam int MODE_DOWN   = 1;

endpackage

// File: rtl/count_sequencer_if.sv
// Command channel of the count sequencer: limit and mode offered over valid/ready.
interface count_sequencer_if #(
    parameter int WIDTH = 4
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_limit;
    logic [1:0]       cmd_mode;

    modport master (
        output cmd_valid,
        output cmd_limit,
        output cmd_mode,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_limit,
        input  cmd_mode,
        output cmd_ready
    );

endinterface

// File: rtl/sync_counter_core.sv
// Loadable up/down counter register; clear wins over load, load wins over enable.
module sync_counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             down,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= load_value;
        end else if (enable) begin
            q <= down ? (q - ONE) : (q + ONE);
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Command-driven controller that runs a counter once (one-shot) or repeatedly (auto-reload).
module count_sequencer
    import count_sequencer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    count_sequencer_if.slave cmd,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done,
    output logic             tc_pulse
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] limit;
    logic [1:0]       mode;
    logic             handshake;
    logic             terminal;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             enable;
    logic             done_next;
    logic             tc_next;

    assign cmd.cmd_ready = (state == IDLE) & ~clear;
    assign handshake     = cmd.cmd_valid & cmd.cmd_ready;
    assign busy          = (state == RUN);
    assign terminal      = mode[MODE_DOWN] ? (Q == '0) : (Q == limit);

    sync_counter_core #(.WIDTH(WIDTH)) counter (
        .clk        (clk),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .enable     (enable),
        .down       (mode[MODE_DOWN]),
        .q          (Q)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state    <= IDLE;
            limit    <= '0;
            mode     <= '0;
            done     <= 1'b0;
            tc_pulse <= 1'b0;
        end else begin
            state    <= state_next;
            done     <= done_next;
            tc_pulse <= tc_next;
            if (handshake) begin
                limit <= cmd.cmd_limit;
                mode  <= cmd.cmd_mode;
            end
        end
    end

    // Terminal is tested ahead of pause so a paused run still completes on its last value.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_value = '0;
        enable     = 1'b0;
        done_next  = 1'b0;
        tc_next    = 1'b0;
        case (state)
            IDLE: begin
                if (handshake) begin
                    load       = 1'b1;
                    load_value = cmd.cmd_mode[MODE_DOWN] ? cmd.cmd_limit : '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    load       = 1'b1;
                    load_value = '0;
                    state_next = IDLE;
                end else if (terminal) begin
                    if (mode[MODE_RELOAD]) begin
                        load       = 1'b1;
                        load_value = mode[MODE_DOWN] ? limit : '0;
                        tc_next    = 1'b1;
                    end else begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end
                end else if (!pause) begin
                    enable = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Synchronous controller that owns a WIDTH-bit counter and runs it under command.
- Accepts a command (limit + mode) over a valid/ready handshake.
- Steps the counter once per clk, pausable, and reports terminal count or completion.
- Fully synchronous replacement for free-running ripple counters, where software or an upstream FSM must sequence count runs.

Parameters:
- WIDTH, 4, counter and limit width in bits

Ports:
- clk  in  1  single system clock, all state updates on posedge
- clear  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_limit  in  WIDTH  terminal value for the run
- cmd_mode  in  2  bit0 = auto-reload (0 one-shot), bit1 = direction (0 up, 1 down)
- pause  in  1  hold count while high
- abort  in  1  terminate current run
- Q  out  WIDTH  current count, registered
- busy  out  1  high while state RUN
- done  out  1  one-cycle pulse at end of one-shot run
- tc_pulse  out  1  one-cycle pulse on each auto-reload wrap

Behaviour:
- Reset (clear=1 at posedge): state=IDLE, Q=0, latched limit/mode=0, done=0, tc_pulse=0. busy=0 and cmd_ready=0 while clear is high. clear overrides every other input. Reset mid-run discards the run with no done.
- States: IDLE, RUN, DONE. cmd_ready = (state==IDLE) & ~clear. busy = (state==RUN).
- IDLE:
  - On a handshake in cycle N: latch limit and mode; Q <= 0 (up) or limit (down); state <= RUN.
  - Q and busy reflect the new run from cycle N+1.
  - Without a handshake, Q holds its last value.
- RUN priority per cycle: abort > terminal > pause > step.
  - abort=1: Q <= 0, state <= IDLE, no done, no tc_pulse.
  - Terminal (Q==limit when up, Q==0 when down):
    - One-shot: state <= DONE, done <= 1, Q holds.
    - Auto-reload: Q <= 0 (up) or limit (down), tc_pulse <= 1, stay in RUN.
  - Terminal is evaluated even while pause=1, so pause cannot mask completion.
  - pause=1 otherwise: Q holds.
  - Step otherwise: Q <= Q+1 (up) or Q-1 (down), modulo 2^WIDTH. Wrap cannot occur before the terminal value because the terminal is always within range.
- DONE: lasts exactly one cycle with done=1; state <= IDLE; Q keeps its final value. abort is ignored in DONE.
- Timing, one-shot up, limit L, handshake at cycle N:
  - Q=k during cycle N+1+k.
  - done high in cycle N+2+L.
  - cmd_ready high again in N+3+L.
  - Each pause cycle adds one cycle.
- limit=0 needs no special case: done occurs at N+2, up or down.
- Auto-reload period is limit+1 cycles. tc_pulse coincides with the cycle Q shows the reload value.
- A command offered while not IDLE is not accepted. cmd_* must be held by the sender until the handshake.
- done, tc_pulse, and Q are registered outputs with no combinational input-to-output path. The only combinational input-to-output path is clear to cmd_ready.

Decomposition:
- Package count_sequencer_pkg:
  - state enum (IDLE, RUN, DONE)
  - mode bit indices (MODE_RELOAD=0, MODE_DOWN=1)
- One natural sub-module, sync_counter_core:
  - WIDTH-bit register with synchronous clear, load, load value, enable, up/down.
  - Drives Q.
  - The FSM stays in count_sequencer.

Test Plan:
- clear held 3 cycles then released, no command -> Q=0, busy=0, done=0, tc_pulse=0; cmd_ready=0 while clear=1 and 1 the cycle after release.
- One-shot up, limit=5, handshake cycle N -> Q=0..5 over N+1..N+6, done=1 only at N+7 with Q=5, cmd_ready=1 at N+8.
- Auto-reload down, limit=3 -> Q sequence 3,2,1,0,3,2,...; tc_pulse high on every cycle Q returns to 3 after the first; busy stays 1.
- One-shot up, limit=4, pause high for 2 cycles at Q=2 -> Q holds 2 for 2 extra cycles; done 2 cycles later than nominal. Separately, with pause held while Q=4 -> done still fires.
- abort at Q=3 (limit=9), then new command same cycle it returns to IDLE+1 -> Q=0, no done, busy=0; second command accepted, runs normally.
- limit=0 one-shot, and clear asserted at Q=2 of a limit=7 run -> first gives done at N+2; second gives IDLE, Q=0, no done next cycle.
